// File: rtl/stream_packer.sv
`default_nettype none
// stream_packer: packs G_RATIO valid/ready input words into one registered output word.
// Optional STREAM_PACKER_LAST_EN adds packet-end flush (s_last_i / m_last_o / m_fill_o).
module stream_packer #(
  parameter int G_DATA_SIZE = 8,
  parameter int G_RATIO     = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           s_valid_i,
  output logic                           s_ready_o,
  input  logic [G_DATA_SIZE-1:0]         s_data_i,
`ifdef STREAM_PACKER_LAST_EN
  input  logic                           s_last_i,
  output logic                           m_last_o,
  output logic [$clog2(G_RATIO+1)-1:0]   m_fill_o,
`endif
  output logic                           m_valid_o,
  input  logic                           m_ready_i,
  output logic [G_RATIO*G_DATA_SIZE-1:0] m_data_o
);

  localparam int CNT_W = $clog2(G_RATIO);
  localparam int OUT_W = G_RATIO * G_DATA_SIZE;

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic [OUT_W-1:0] word;
  logic             in_xfer;
  logic             done;

`ifdef STREAM_PACKER_LAST_EN
  localparam int FILL_W = $clog2(G_RATIO + 1);
  logic              last_q, last_d;
  logic [FILL_W-1:0] fill_q, fill_d;

  assign m_last_o = last_q;
  assign m_fill_o = fill_q;
`endif

  // Ready depends only on registered state and downstream ready, so a
  // completed word can be drained and replaced in the same cycle.
  assign s_ready_o = (state_q == ST_FILL) || m_ready_i;
  assign m_valid_o = (state_q == ST_FULL);
  assign m_data_o  = data_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    data_d  = data_q;
    in_xfer = s_valid_i && s_ready_o;
    word    = acc_q;
    word[int'(cnt_q)*G_DATA_SIZE +: G_DATA_SIZE] = s_data_i;
    done    = (cnt_q == CNT_W'(G_RATIO - 1));
`ifdef STREAM_PACKER_LAST_EN
    last_d  = last_q;
    fill_d  = fill_q;
    // A short packet must not leak stale slots from an earlier word.
    for (int i = 0; i < G_RATIO; i++) begin
      if (s_last_i && (i > int'(cnt_q))) begin
        word[i*G_DATA_SIZE +: G_DATA_SIZE] = '0;
      end
    end
    done = done || s_last_i;
`endif

    if ((state_q == ST_FULL) && m_ready_i) begin
      state_d = ST_FILL;
    end

    if (in_xfer) begin
      if (done) begin
        data_d  = word;
        state_d = ST_FULL;
        cnt_d   = '0;
`ifdef STREAM_PACKER_LAST_EN
        last_d  = s_last_i;
        fill_d  = FILL_W'(cnt_q) + FILL_W'(1);
`endif
      end else begin
        acc_d = word;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_FILL;
      cnt_q   <= '0;
      acc_q   <= '0;
      data_q  <= '0;
`ifdef STREAM_PACKER_LAST_EN
      last_q  <= 1'b0;
      fill_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
`ifdef STREAM_PACKER_LAST_EN
      last_q  <= last_d;
      fill_q  <= fill_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stream_packer.sv
`default_nettype none
// tb_stream_packer: scoreboard bench; a packet-level model predicts packed words
// from accepted input words, a separate monitor checks every output handshake.
module tb_stream_packer;

  localparam int DW    = 8;
  localparam int RATIO = 4;
  localparam int OW    = DW * RATIO;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          s_valid_i = 1'b0;
  logic          s_ready_o;
  logic [DW-1:0] s_data_i = '0;
  logic          s_last_i = 1'b0;
  logic          m_valid_o;
  logic          m_ready_i = 1'b1;
  logic [OW-1:0] m_data_o;
  logic          m_last_o;
  logic [2:0]    m_fill_o;

  stream_packer #(.G_DATA_SIZE(DW), .G_RATIO(RATIO)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .s_valid_i (s_valid_i),
    .s_ready_o (s_ready_o),
    .s_data_i  (s_data_i),
`ifdef STREAM_PACKER_LAST_EN
    .s_last_i  (s_last_i),
    .m_last_o  (m_last_o),
    .m_fill_o  (m_fill_o),
`endif
    .m_valid_o (m_valid_o),
    .m_ready_i (m_ready_i),
    .m_data_o  (m_data_o)
  );

`ifndef STREAM_PACKER_LAST_EN
  assign m_last_o = 1'b0;
  assign m_fill_o = 3'(RATIO);
`endif

  always #5 clk_i = ~clk_i;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model state: accepted words of the current packet and predicted outputs.
  logic [DW-1:0] q_in[$];
  logic [OW-1:0] exp_data[$];
  logic          exp_last[$];
  int            exp_fill[$];
  bit            chk_valid_next = 0;
  bit            rand_ready = 0;

  task automatic check(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_accept(input logic [DW-1:0] d, input logic last);
    logic [OW-1:0] w;
    q_in.push_back(d);
`ifndef STREAM_PACKER_LAST_EN
    last = 1'b0;
`endif
    if (q_in.size() == RATIO || last) begin
      w = '0;
      foreach (q_in[i]) w[i*DW +: DW] = q_in[i];
      exp_data.push_back(w);
      exp_last.push_back(last);
      exp_fill.push_back(q_in.size());
      q_in.delete();
      chk_valid_next = 1;
    end
  endtask

  // Observe one cycle at the falling edge, then move to just after the rising edge.
  task automatic obs(output bit accepted);
    @(negedge clk_i);
    if (chk_valid_next) begin
      check(m_valid_o === 1'b1, "latency_valid", 64'(m_valid_o), 64'd1);
      chk_valid_next = 0;
    end
    accepted = s_valid_i && s_ready_o && !rst_i;
    if (accepted) model_accept(s_data_i, s_last_i);
    @(posedge clk_i);
    #1;
    if (rand_ready) m_ready_i = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [DW-1:0] d, input logic last);
    bit acc;
    s_valid_i = 1'b1;
    s_data_i  = d;
    s_last_i  = last;
    for (int k = 0; k < 200; k++) begin
      obs(acc);
      if (acc) break;
      if (k == 199) check(1'b0, "send_timeout", 64'd0, 64'd1);
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
    for (int k = 0; k < n; k++) obs(acc);
  endtask

  task automatic do_reset(input int n);
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
    rst_i = 1'b1;
    q_in.delete();
    exp_data.delete();
    exp_last.delete();
    exp_fill.delete();
    chk_valid_next = 0;
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
    rst_i = 1'b0;
  endtask

  // Monitor: pops and compares on every output handshake, checks hold stability.
  bit            hold_prev = 0;
  logic [OW-1:0] data_prev;
  always @(negedge clk_i) begin
    if (rst_i) begin
      hold_prev = 0;
    end else begin
      if (hold_prev) begin
        check(m_valid_o === 1'b1, "hold_valid", 64'(m_valid_o), 64'd1);
        check(m_data_o === data_prev, "hold_data", 64'(m_data_o), 64'(data_prev));
      end
      check(s_ready_o === (!m_valid_o || m_ready_i), "s_ready", 64'(s_ready_o),
            64'(!m_valid_o || m_ready_i));
      if (m_valid_o && m_ready_i) begin
        if (exp_data.size() == 0) begin
          check(1'b0, "spurious_output", 64'(m_data_o), 64'd0);
        end else begin
          logic [OW-1:0] ed;
          logic          el;
          int            ef;
          ed = exp_data.pop_front();
          el = exp_last.pop_front();
          ef = exp_fill.pop_front();
          check(m_data_o === ed, "m_data", 64'(m_data_o), 64'(ed));
`ifdef STREAM_PACKER_LAST_EN
          check(m_last_o === el, "m_last", 64'(m_last_o), 64'(el));
          check(int'(m_fill_o) == ef, "m_fill", 64'(m_fill_o), 64'(ef));
`endif
        end
      end
      hold_prev = m_valid_o && !m_ready_i;
      data_prev = m_data_o;
    end
  end

  initial begin
    bit acc;
    // Reset held for two cycles.
    do_reset(2);
    @(negedge clk_i);
    check(m_valid_o === 1'b0, "rst_valid", 64'(m_valid_o), 64'd0);
    check(m_data_o === '0, "rst_data", 64'(m_data_o), 64'd0);
    check(s_ready_o === 1'b1, "rst_ready", 64'(s_ready_o), 64'd1);
    @(posedge clk_i);
    #1;

    // Single word, then two back-to-back words.
    m_ready_i = 1'b1;
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
    idle(3);
    for (int i = 1; i <= 8; i++) send(8'(i), 0);
    idle(3);

    // Backpressure: full word held while 0x55 waits, then lands in slot 0.
    m_ready_i = 1'b0;
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
    s_valid_i = 1'b1;
    s_data_i  = 8'h55;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      check(s_ready_o === 1'b0, "bp_ready_low", 64'(s_ready_o), 64'd0);
      @(posedge clk_i);
      #1;
    end
    m_ready_i = 1'b1;
    obs(acc);
    check(acc, "bp_accept_55", 64'(acc), 64'd1);
    send(8'h66, 0); send(8'h77, 0); send(8'h88, 0);
    idle(3);

    // Reset in the middle of a fill.
    send(8'hAA, 0); send(8'hBB, 0);
    do_reset(1);
    for (int i = 1; i <= 4; i++) send(8'(i), 0);
    idle(3);

`ifdef STREAM_PACKER_LAST_EN
    send(8'hAA, 0); send(8'hBB, 1);
    for (int i = 1; i <= 4; i++) send(8'(i), 0);
    idle(3);
`endif

    // Randomized traffic with random backpressure and gaps.
    rand_ready = 1;
    for (int n = 0; n < 400; n++) begin
      send(8'($urandom), ($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end
    rand_ready = 0;
    m_ready_i  = 1'b1;
    idle(6);
    check(exp_data.size() == 0, "scoreboard_drained", 64'(exp_data.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
